// File: rtl/port_tx_gen.sv
// port_tx_gen: burst packet generator feeding one switch port, with LFSR-chosen targets and backpressure handling
module port_tx_gen #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num_pkts,
    input  logic [1:0]  port_id,
    input  logic [3:0]  target_mask,
    input  logic [3:0]  gap_cycles,
    input  logic        full_in,
    output logic        pkt_valid,
    output logic [3:0]  pkt_source,
    output logic [3:0]  pkt_target,
    output logic [7:0]  pkt_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] sent_cnt,
    output logic [15:0] blocked_cnt
);
    localparam logic [7:0] SEED_NZ = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [2:0] {IDLE, GEN, SEND, GAP, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  lfsr;
    logic [15:0] num_q;
    logic [1:0]  port_q;
    logic [3:0]  mask_q, gap_q, gap_cnt;
    logic [7:0]  lfsr_nxt;
    logic [3:0]  tgt_raw, tgt_low;

    assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign tgt_raw  = lfsr_nxt[3:0] & mask_q;
    assign tgt_low  = mask_q & (~mask_q + 4'd1);

    // next-state decode; start outside IDLE falls through unseen
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (num_pkts == 16'd0 || target_mask == 4'd0) ? DONE : GEN;
            GEN:  state_nxt = SEND;
            SEND: if (!full_in) state_nxt = (sent_cnt + 16'd1 == num_q) ? DONE : (gap_q != 4'd0 ? GAP : GEN);
            GAP:  if (gap_cnt == 4'd0) state_nxt = GEN;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state, configuration, LFSR, packet fields and counters, all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lfsr        <= SEED_NZ;
            num_q       <= '0;
            port_q      <= '0;
            mask_q      <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            pkt_valid   <= 1'b0;
            pkt_source  <= '0;
            pkt_target  <= '0;
            pkt_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sent_cnt    <= '0;
            blocked_cnt <= '0;
        end else begin
            state <= state_nxt;
            busy  <= state_nxt == GEN || state_nxt == SEND || state_nxt == GAP;
            done  <= state_nxt == DONE;
            if (state == IDLE && start) begin
                num_q       <= num_pkts;
                port_q      <= port_id;
                mask_q      <= target_mask;
                gap_q       <= gap_cycles;
                sent_cnt    <= '0;
                blocked_cnt <= '0;
            end
            if (state == GEN) begin
                lfsr       <= lfsr_nxt;
                pkt_target <= (tgt_raw != 4'd0) ? tgt_raw : tgt_low;
                pkt_source <= 4'b0001 << port_q;
                pkt_data   <= sent_cnt[7:0];
                pkt_valid  <= 1'b1;
            end
            if (state == SEND && full_in && blocked_cnt != 16'hFFFF)
                blocked_cnt <= blocked_cnt + 16'd1;
            if (state == SEND && !full_in) begin
                sent_cnt  <= sent_cnt + 16'd1;
                pkt_valid <= 1'b0;
                gap_cnt   <= gap_q - 4'd1;
            end
            if (state == GAP)
                gap_cnt <= gap_cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_port_tx_gen.sv
// tb_port_tx_gen: directed bursts checked cycle by cycle against a packet-schedule model
module tb_port_tx_gen;
    localparam int MAXC = 128;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_pkts = '0;
    logic [1:0]  port_id = '0;
    logic [3:0]  target_mask = '0;
    logic [3:0]  gap_cycles = '0;
    logic        full_in = 1'b0;
    logic        pkt_valid, busy, done;
    logic [3:0]  pkt_source, pkt_target;
    logic [7:0]  pkt_data;
    logic [15:0] sent_cnt, blocked_cnt;

    port_tx_gen #(.SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .num_pkts(num_pkts), .port_id(port_id),
        .target_mask(target_mask), .gap_cycles(gap_cycles), .full_in(full_in),
        .pkt_valid(pkt_valid), .pkt_source(pkt_source), .pkt_target(pkt_target),
        .pkt_data(pkt_data), .busy(busy), .done(done), .sent_cnt(sent_cnt), .blocked_cnt(blocked_cnt)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // expected per-cycle view of a burst, cycle 0 being the start cycle
    logic        fp [0:MAXC-1];
    logic        e_v [0:MAXC-1], e_busy [0:MAXC-1], e_done [0:MAXC-1];
    logic [3:0]  e_src [0:MAXC-1], e_tgt [0:MAXC-1];
    logic [7:0]  e_dat [0:MAXC-1];
    logic [15:0] e_sent [0:MAXC-1], e_blk [0:MAXC-1];
    logic        sv [0:MAXC-1], sdone [0:MAXC-1];
    logic [3:0]  st [0:MAXC-1], ss [0:MAXC-1];
    logic [7:0]  sd [0:MAXC-1];
    logic [15:0] ssent [0:MAXC-1], sblk [0:MAXC-1];

    logic [7:0]  m_lfsr = SEED;
    logic [15:0] prev_s = '0, prev_b = '0;
    logic [3:0]  prev_src = '0, prev_tgt = '0;
    logic [7:0]  prev_dat = '0;
    int          n_cyc = 0;
    logic        run = 1'b0;
    time         t0 = 0;
    int          c;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] lstep(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [3:0] lowest(input logic [3:0] m);
        logic [3:0] r = '0;
        for (int i = 3; i >= 0; i--) if (m[i]) r = 4'(1 << i);
        return r;
    endfunction

    // schedule the burst: each packet waits out the full cycles, then gap+GEN before the next
    task automatic build(input int num, input logic [1:0] port, input logic [3:0] mask, input logic [3:0] gap);
        int t, dt;
        logic [3:0] tg;
        logic inc_s [0:MAXC-1];
        logic inc_b [0:MAXC-1];
        logic [15:0] cs, cb;
        for (int i = 0; i < MAXC; i++) begin
            e_v[i] = 0; e_busy[i] = 0; e_done[i] = 0; inc_s[i] = 0; inc_b[i] = 0;
            e_tgt[i] = '0; e_src[i] = '0; e_dat[i] = '0;
        end
        dt = 1;
        if (num != 0 && mask != 0) begin
            t = 2;
            for (int p = 0; p < num; p++) begin
                m_lfsr = lstep(m_lfsr);
                tg = m_lfsr[3:0] & mask;
                if (tg == 0) tg = lowest(mask);
                while (fp[t] && t < MAXC - 8) begin
                    e_v[t] = 1; e_tgt[t] = tg; e_dat[t] = 8'(p); e_src[t] = 4'(1 << port); inc_b[t] = 1; t++;
                end
                e_v[t] = 1; e_tgt[t] = tg; e_dat[t] = 8'(p); e_src[t] = 4'(1 << port); inc_s[t] = 1;
                if (p == num - 1) dt = t + 1;
                else t = t + int'(gap) + 2;
            end
        end
        e_done[dt] = 1;
        for (int i = 1; i < dt; i++) e_busy[i] = 1;
        n_cyc = dt + 3;
        cs = prev_s; cb = prev_b;
        for (int i = 0; i < MAXC; i++) begin
            if (i == 1) begin cs = 0; cb = 0; end
            if (e_v[i]) begin prev_src = e_src[i]; prev_tgt = e_tgt[i]; prev_dat = e_dat[i]; end
            e_src[i] = prev_src; e_tgt[i] = prev_tgt; e_dat[i] = prev_dat;
            e_sent[i] = cs; e_blk[i] = cb;
            cs = cs + 16'(inc_s[i]);
            if (inc_b[i] && cb != 16'hFFFF) cb = cb + 16'd1;
        end
        prev_s = cs; prev_b = cb;
    endtask

    // every cycle of an active burst: DUT against model, plus a snapshot for literal checks
    always @(negedge clk) begin
        if (run) begin
            c = int'(($time - t0 + 1) / 10);
            if (c < n_cyc) begin
                sv[c] = pkt_valid; st[c] = pkt_target; ss[c] = pkt_source; sd[c] = pkt_data;
                sdone[c] = done; ssent[c] = sent_cnt; sblk[c] = blocked_cnt;
                chk($sformatf("c%0d valid", c), 16'(pkt_valid), 16'(e_v[c]));
                chk($sformatf("c%0d busy", c), 16'(busy), 16'(e_busy[c]));
                chk($sformatf("c%0d done", c), 16'(done), 16'(e_done[c]));
                chk($sformatf("c%0d source", c), 16'(pkt_source), 16'(e_src[c]));
                chk($sformatf("c%0d target", c), 16'(pkt_target), 16'(e_tgt[c]));
                chk($sformatf("c%0d data", c), 16'(pkt_data), 16'(e_dat[c]));
                chk($sformatf("c%0d sent_cnt", c), sent_cnt, e_sent[c]);
                chk($sformatf("c%0d blocked_cnt", c), blocked_cnt, e_blk[c]);
            end
        end
    end

    task automatic run_burst(input int num, input logic [1:0] port, input logic [3:0] mask,
                             input logic [3:0] gap, input int xs);
        build(num, port, mask, gap);
        @(posedge clk); #1;
        num_pkts = 16'(num); port_id = port; target_mask = mask; gap_cycles = gap;
        t0 = $time; run = 1;
        for (int i = 0; i < n_cyc; i++) begin
            start = (i == 0) || (i == xs);
            full_in = fp[i];
            @(posedge clk); #1;
        end
        run = 0; start = 0; full_in = 0;
    endtask

    task automatic clear_fp();
        for (int i = 0; i < MAXC; i++) fp[i] = 0;
    endtask

    initial begin
        int nd;
        clear_fp();
        #12;
        chk("reset valid", 16'(pkt_valid), 16'd0);
        chk("reset busy", 16'(busy), 16'd0);
        chk("reset done", 16'(done), 16'd0);
        chk("reset fields", {pkt_source, pkt_target, pkt_data}, 16'd0);
        chk("reset sent", sent_cnt, 16'd0);
        chk("reset blocked", blocked_cnt, 16'd0);
        rst = 0;
        repeat (2) @(posedge clk);

        // basic burst
        run_burst(3, 2'd2, 4'hF, 4'd0, -1);
        chk("basic v2", 16'(sv[2]), 16'd1);
        chk("basic v3", 16'(sv[3]), 16'd0);
        chk("basic v4", 16'(sv[4]), 16'd1);
        chk("basic v6", 16'(sv[6]), 16'd1);
        chk("basic src", 16'(ss[2]), 16'h4);
        chk("basic tgt0", 16'(st[2]), 16'hA);
        chk("basic tgt1", 16'(st[4]), 16'h5);
        chk("basic tgt2", 16'(st[6]), 16'hA);
        chk("basic d1", 16'(sd[4]), 16'd1);
        chk("basic d2", 16'(sd[6]), 16'd2);
        chk("basic done7", 16'(sdone[7]), 16'd1);
        chk("basic sent7", ssent[7], 16'd3);

        // backpressure for five cycles starting at the first valid
        clear_fp();
        for (int i = 2; i <= 6; i++) fp[i] = 1;
        run_burst(1, 2'd0, 4'hF, 4'd0, -1);
        for (int i = 2; i <= 7; i++) chk($sformatf("bp valid c%0d", i), 16'(sv[i]), 16'd1);
        chk("bp target stable", 16'(st[7]), 16'(st[2]));
        chk("bp done8", 16'(sdone[8]), 16'd1);
        chk("bp blocked", sblk[8], 16'd5);
        chk("bp sent", ssent[8], 16'd1);
        clear_fp();

        // single-bit mask forces every target
        run_burst(4, 2'd3, 4'b1000, 4'd0, -1);
        for (int i = 2; i <= 8; i += 2) chk($sformatf("mask8 tgt c%0d", i), 16'(st[i]), 16'h8);
        chk("mask8 src", 16'(ss[2]), 16'h8);

        // empty mask ends immediately
        run_burst(5, 2'd1, 4'b0000, 4'd2, -1);
        chk("mask0 done1", 16'(sdone[1]), 16'd1);
        chk("mask0 sent", ssent[1], 16'd0);
        nd = 0;
        for (int i = 0; i < n_cyc; i++) nd += int'(sv[i]);
        chk("mask0 no valid", 16'(nd), 16'd0);

        // gap of three with a stray start while busy
        run_burst(2, 2'd1, 4'hF, 4'd3, 3);
        chk("gap v2", 16'(sv[2]), 16'd1);
        chk("gap v7", 16'(sv[7]), 16'd1);
        chk("gap v5", 16'(sv[5]), 16'd0);
        nd = 0;
        for (int i = 0; i < n_cyc; i++) nd += int'(sdone[i]);
        chk("gap one done", 16'(nd), 16'd1);

        // random backpressure
        clear_fp();
        for (int i = 2; i < 40; i++) fp[i] = 1'($urandom_range(0, 1));
        run_burst(6, 2'd1, 4'b0110, 4'd1, -1);
        clear_fp();

        // reset while packet 2 of 4 is in SEND
        build(4, 2'd2, 4'hF, 4'd0);
        @(posedge clk); #1;
        num_pkts = 16'd4; port_id = 2'd2; target_mask = 4'hF; gap_cycles = 4'd0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre-rst valid", 16'(pkt_valid), 16'd1);
        #2 rst = 1;
        #1;
        chk("rst async valid", 16'(pkt_valid), 16'd0);
        chk("rst counters", sent_cnt | blocked_cnt, 16'd0);
        chk("rst busy", 16'(busy), 16'd0);
        #3 rst = 0;
        nd = 0;
        repeat (4) begin @(posedge clk); #1; nd += int'(done) + int'(pkt_valid) + int'(busy); end
        chk("post-rst idle", 16'(nd), 16'd0);
        m_lfsr = SEED; prev_s = 0; prev_b = 0; prev_src = 0; prev_tgt = 0; prev_dat = 0;
        run_burst(4, 2'd2, 4'hF, 4'd0, -1);
        chk("replay tgt0", 16'(st[2]), 16'hA);
        chk("replay tgt1", 16'(st[4]), 16'h5);
        chk("replay tgt2", 16'(st[6]), 16'hA);
        chk("replay tgt3", 16'(st[8]), 16'h4);
        chk("replay sent", ssent[9], 16'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/port_tx_gen.md
PORT_TX_GEN -- requirements
Module: port_tx_gen

Interface
REQ-001 Parameter SEED, default 8'hA5, initial value of the 8-bit LFSR; a value of 0 is replaced by 8'h01.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a burst.
REQ-005 num_pkts  input  16  number of packets in the burst, sampled at start.
REQ-006 port_id  input  2  source port number, sampled at start.
REQ-007 target_mask  input  4  permitted destination ports, sampled at start.
REQ-008 gap_cycles  input  4  idle cycles between packets, sampled at start.
REQ-009 full_in  input  1  backpressure from the switch port FIFO (fifo_full).
REQ-010 pkt_valid  output  1  packet offered to the switch port (drives valid_in).
REQ-011 pkt_source  output  4  one-hot source (drives source_in).
REQ-012 pkt_target  output  4  destination mask (drives target_in).
REQ-013 pkt_data  output  8  payload (drives data_in).
REQ-014 busy  output  1  burst in progress.
REQ-015 done  output  1  one-cycle pulse when the burst completes.
REQ-016 sent_cnt  output  16  packets accepted in the current or last burst.
REQ-017 blocked_cnt  output  16  cycles with pkt_valid=1 and full_in=1 in the current or last burst.

Function
REQ-018 The FSM SHALL have states IDLE, GEN, SEND, GAP and DONE; all outputs SHALL be registered.
REQ-019 IDLE: on start=1 the block SHALL latch the configuration inputs and clear sent_cnt and blocked_cnt.
- num_pkts=0 or target_mask=0: next state DONE.
- otherwise: next state GEN.
REQ-020 start received in any state other than IDLE SHALL be ignored.
REQ-021 GEN (1 cycle): the LFSR SHALL advance once (x^8+x^6+x^5+x^4+1, Fibonacci form, shift left, feedback into bit 0).
- pkt_target = new lfsr[3:0] & mask; if this is zero, the lowest set bit of mask is used instead.
- pkt_source = 1<<port_id.
- pkt_data = sent_cnt[7:0].
- next state SEND.
REQ-022 SEND: pkt_valid=1.
- A packet is accepted in a cycle where pkt_valid=1 and full_in=0.
- On acceptance: sent_cnt increments and pkt_valid drops on the next edge.
- Next state: DONE if sent_cnt+1==num_pkts; otherwise GAP if gap_cycles>0; otherwise GEN.
REQ-023 SEND with full_in=1: the block SHALL remain in SEND, hold pkt_valid, pkt_source, pkt_target and pkt_data stable, and increment blocked_cnt (saturating at 16'hFFFF).
- The block never drops a packet.
REQ-024 GAP SHALL hold pkt_valid=0 for exactly gap_cycles cycles, then go to GEN.
REQ-025 DONE SHALL assert done for 1 cycle and drop busy, then go to IDLE.
- sent_cnt and blocked_cnt hold their values until the next accepted start.
REQ-026 busy SHALL be 1 in GEN, SEND and GAP, and 0 in IDLE and DONE.
REQ-027 Latency: start in cycle 0 -> pkt_valid=1 in cycle 2 when full_in=0.
- Back-to-back packets with gap_cycles=0 SHALL occur at most once every 2 cycles.
REQ-028 pkt_source, pkt_target and pkt_data SHALL hold their last values when pkt_valid=0.
- The switch ignores them at that time.

Reset
REQ-029 While rst=1 the block SHALL asynchronously force:
- state IDLE, LFSR=SEED;
- pkt_valid=0, pkt_source=0, pkt_target=0, pkt_data=0;
- busy=0, done=0, sent_cnt=0, blocked_cnt=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst: pkt_valid=0 immediately, with no done pulse.
- After rst falls, the block SHALL wait for a fresh start.
REQ-031 The block SHALL take no action on the first rising clock edge after rst deasserts unless start=1 on that edge.

Verification
REQ-032 Basic burst: start, num_pkts=3, port_id=2, mask=4'hF, gap=0, full_in=0.
- Expect 3 valid pulses at cycles 2, 4, 6, each with pkt_source=4'b0100 and pkt_data=0,1,2.
- Expect done in cycle 7 and sent_cnt=3.
REQ-033 Backpressure: full_in=1 for 5 cycles from the first valid, num_pkts=1.
- Expect pkt_valid and payload stable for 6 cycles, accepted once, blocked_cnt=5 and sent_cnt=1.
REQ-034 Mask handling: mask=4'b1000.
- Every pkt_target must be 4'b1000.
- With mask=0: expect done in cycle 1, no pkt_valid, sent_cnt=0.
REQ-035 Gap and ignore-start: num_pkts=2, gap=3, and a second start pulse while busy.
- Valid pulses 5 cycles apart (cycles 2 and 7).
- The second start has no effect and exactly one done pulse occurs.
REQ-036 Reset mid-burst: rst pulse while in SEND of packet 2 of 4.
- pkt_valid=0 asynchronously, counters=0, no done.
- A new start then replays the LFSR sequence from SEED with identical targets.
REQ-037 Integration: four instances drive the switch ports with 200 packets each and random full_in.
- Expected result: zero input drops and every accepted packet delivered.
